// File: rtl/monitor_report_collector.sv
// Timestamped capture FIFO for the LTL monitor cluster report vector.
// Keeps sticky hit/overflow status and a saturating drop counter.
module monitor_report_collector #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [9:0]               ltl_hits,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W+9:0]          out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [9:0]               sticky_hits,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TS_W + 10;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            capture;
  logic            pop;
  logic            push;
  logic            drop;
  logic [7:0]      drop_base;

  assign capture   = run && (ltl_hits != '0);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a record when the head leaves this cycle.
  assign push      = capture && ((count != FULL) || pop);
  assign drop      = capture && !push;
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign drop_base = clear ? 8'd0 : drop_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {ts, ltl_hits};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts    <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (run) begin
        ts <= ts + TS_W'(1);
      end
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear takes effect before the same-cycle capture or drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sticky_hits <= '0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      sticky_hits <= (clear ? 10'd0 : sticky_hits)
                   | (capture ? ltl_hits : 10'd0);
      overflow    <= (clear ? 1'b0 : overflow) | drop;
      if (drop && (drop_base != 8'hFF)) begin
        drop_cnt <= drop_base + 8'd1;
      end else begin
        drop_cnt <= drop_base;
      end
    end
  end

endmodule

// File: tb/tb_monitor_report_collector.sv
// Randomized scoreboard bench for monitor_report_collector.
// Queue-based reference model; monitor checks every handshake.
module tb_monitor_report_collector;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int DW    = TS_W + 10;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [9:0]    ltl_hits;
  logic          clear;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic [9:0]    sticky_hits;
  logic          overflow;
  logic [7:0]    drop_cnt;

  monitor_report_collector #(
    .DEPTH(DEPTH),
    .TS_W (TS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .ltl_hits   (ltl_hits),
    .clear      (clear),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .count      (count),
    .sticky_hits(sticky_hits),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [$];
  int            occ;
  int            ts_m;
  logic [9:0]    m_sticky;
  logic          m_ovf;
  int            m_drop;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(out_data), 64'hDEAD);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Checks state left by the previous edge, then issues one cycle.
  task automatic cyc(input logic rn, input logic r, input logic [9:0] h,
                     input logic c, input logic rd);
    logic cap;
    logic popx;
    chk("count", 64'(count), 64'(occ));
    chk("out_valid", 64'(out_valid), 64'(occ != 0));
    chk("sticky_hits", 64'(sticky_hits), 64'(m_sticky));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (occ == 0) chk("idle_data", 64'(out_data), 64'd0);
    reset = rn; run = r; ltl_hits = h; clear = c; out_ready = rd;
    if (!rn) begin
      exp_q.delete();
      occ = 0; ts_m = 0; m_sticky = '0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      cap  = r && (h != 0);
      popx = rd && (occ > 0);
      if (c) begin
        m_sticky = '0; m_ovf = 1'b0; m_drop = 0;
      end
      if (cap) begin
        m_sticky = m_sticky | h;
        if (occ < DEPTH || popx) begin
          exp_q.push_back({TS_W'(ts_m), h});
          occ++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (popx) occ--;
      if (r) ts_m = (ts_m + 1) % (1 << TS_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int n, input int rdy_pct,
                            input int clr_pct, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      logic [9:0] h;
      h = ($urandom_range(99) < 50) ? 10'($urandom_range(1023)) : 10'd0;
      cyc(!($urandom_range(999) < rst_pct * 10),
          $urandom_range(99) < 90, h,
          $urandom_range(99) < clr_pct,
          $urandom_range(99) < rdy_pct);
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; ltl_hits = '0;
    clear = 1'b0; out_ready = 1'b0;
    occ = 0; ts_m = 0; m_sticky = '0; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_status", 64'({sticky_hits, overflow, drop_cnt}), 64'd0);

    for (int i = 0; i < 5; i++) cyc(1, 1, 10'h000, 0, 1);
    cyc(1, 1, 10'h004, 0, 1);
    cyc(1, 1, 10'h000, 0, 0);
    cyc(1, 1, 10'h001, 0, 0);
    cyc(1, 1, 10'h200, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 10'h000, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 10'h3FF, 0, 1);

    rand_phase(400, 60, 3, 0);

    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 10'($urandom_range(1023, 1)), 0, 0);
    end
    cyc(1, 1, 10'h155, 0, 1);
    cyc(1, 1, 10'h003, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 10'h000, 0, 1);

    rand_phase(500, 30, 2, 1);
    rand_phase(300, 80, 1, 1);

    for (int i = 0; i < 3; i++) cyc(1, 1, 10'h0F0, 0, 0);
    cyc(0, 1, 10'h0F0, 1, 1);
    cyc(1, 0, 10'h000, 0, 1);

    for (int i = 0; i < 12; i++) cyc(1, 0, 10'h000, 0, 1);
    chk("leftover", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/monitor_report_collector.md
MONITOR_REPORT_COLLECTOR -- requirements
Module: monitor_report_collector

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 Parameter TS_W, default 24, timestamp width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 run  input  1  monitor enable, same signal that drives the automata cluster.
REQ-006 ltl_hits  input  10  per-cycle LTL report vector; bit i = ltl{i}c5lw output of the cluster.
REQ-007 clear  input  1  single-cycle pulse; clears the sticky status (REQ-021).
REQ-008 out_ready  input  1  downstream accepts the head record.
REQ-009 out_valid  output  1  head record available.
REQ-010 out_data  output  TS_W+10  record {timestamp[TS_W-1:0], hits[9:0]}, hits in LSBs.
REQ-011 count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 sticky_hits  output  10  OR of all hits captured since the last reset or clear.
REQ-013 overflow  output  1  sticky flag, set when any record is dropped.
REQ-014 drop_cnt  output  8  dropped-record count, saturating.

Function
REQ-015 Timestamp counter SHALL increment by 1 in each cycle with run=1, hold when run=0, and wrap from 2^TS_W-1 to 0.
REQ-016 Capture: in a cycle with run=1 and ltl_hits!=0, a push SHALL be requested with record {current timestamp (pre-increment value), ltl_hits}.
REQ-017 A cycle with run=0 or ltl_hits==0 SHALL NOT request a push; pops SHALL still be serviced while run=0.
REQ-018 Pop SHALL occur in a cycle when out_valid=1 and out_ready=1; the next record, if any, SHALL be presented the following cycle.
REQ-019 The FIFO SHALL be registered, with no fall-through: a record pushed into an empty FIFO SHALL raise out_valid exactly 1 cycle later.
REQ-020 Handshake: out_data SHALL stay stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop without a pop.
REQ-021 Full: a push SHALL be accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. Otherwise the record SHALL be dropped: overflow<=1 and drop_cnt<=drop_cnt+1, saturating at 255. The FIFO contents SHALL remain unchanged.
REQ-022 Empty: a pop SHALL never occur while out_valid=0; a push with no pop into an empty FIFO SHALL give count=1.
REQ-023 count SHALL update as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 sticky_hits SHALL OR in ltl_hits of every capture cycle (REQ-016), including dropped records.
REQ-026 clear SHALL zero sticky_hits, overflow and drop_cnt; it SHALL NOT flush the FIFO or the timestamp counter.
REQ-027 clear coinciding with a capture or drop: the clear SHALL apply first, then the same-cycle event. Result: sticky_hits=ltl_hits; on a drop, overflow=1 and drop_cnt=1.

Reset
REQ-028 With reset=0 at a clk edge, the block SHALL reset. Timestamp=0, pointers=0, count=0, out_valid=0, out_data=0, sticky_hits=0, overflow=0, drop_cnt=0.
REQ-029 Reset SHALL dominate run, clear and all handshakes; a reset mid-operation SHALL discard all queued records.
REQ-030 No capture SHALL occur in the first cycle after reset is released unless run=1 and ltl_hits!=0 in that cycle.

Verification
REQ-031 Single capture: run=1 from reset release; ltl_hits=10'h004 at timestamp 5, out_ready=1 -> out_valid=1 the next cycle with out_data={24'd5,10'h004}; sticky_hits=10'h004.
REQ-032 Backpressure: out_ready=0; hits 10'h001 then 10'h200 on consecutive cycles -> out_data holds the first record until out_ready=1; the second record follows on the next cycle; count goes 1,2,1,0.
REQ-033 Overflow: out_ready=0; 10 consecutive cycles with nonzero hits, DEPTH=8 -> count=8, overflow=1, drop_cnt=2; draining returns the first 8 timestamps in order.
REQ-034 Full and simultaneous: count=8 with out_ready=1 and a hit in the same cycle -> push accepted, count stays 8, drop_cnt unchanged.
REQ-035 Clear and wrap: TS_W=4, run=1 for 20 cycles -> timestamp wraps 15->0; clear coincident with a drop -> overflow=1, drop_cnt=1.
REQ-036 Reset mid-stream: 3 records queued, reset=0 for 1 cycle -> count=0, out_valid=0, all status cleared the next cycle.
